// File: rtl/adc_bcd_display.sv
// ---------------------------------------------------------------------------
// adc_bcd_display
//
// Purpose:
//   Converts each binary ADC sample to three BCD digits using a sequential
//   double-dabble (shift-add-3) engine. The three digits are then shown one
//   at a time on a shared 4-bit bcd bus that feeds a seven-segment decoder.
//   A one-hot digit enable drives the common pins. Leading zeros can
//   optionally be blanked.
//
// Parameters:
//   DATA_W    sample width, 1..9, so the result always fits in 3 BCD digits
//   SCAN_DIV  clock cycles each digit stays on the display (>= 1)
//
// Ports:
//   CLK           in   system clock, all logic on the rising edge
//   Reset         in   synchronous active-high reset
//   sample        in   binary ADC result
//   sample_valid  in   sample present, accepted only while idle
//   blank_lz      in   1 = blank leading zeros on the display
//   busy          out  conversion in progress
//   done          out  single-cycle pulse when the digit outputs update
//   hundreds      out  BCD hundreds digit of the last completed conversion
//   tens          out  BCD tens digit
//   units         out  BCD units digit
//   bcd           out  scanned digit for the seven-seg decoder, 4'hF = blank
//   digit_en      out  one-hot digit select: 001=units, 010=tens, 100=hundreds
// ---------------------------------------------------------------------------
module adc_bcd_display #(
  parameter int DATA_W   = 7,
  parameter int SCAN_DIV = 1024
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [DATA_W-1:0] sample,
  input  logic              sample_valid,
  input  logic              blank_lz,
  output logic              busy,
  output logic              done,
  output logic [3:0]        hundreds,
  output logic [3:0]        tens,
  output logic [3:0]        units,
  output logic [3:0]        bcd,
  output logic [2:0]        digit_en
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // A 4-bit counter covers every legal DATA_W (up to 9 shifts).
  localparam logic [3:0] BIT_COUNT = 4'(DATA_W);

  // A single-cycle scan period still needs a 1-bit prescaler that never
  // leaves zero.
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SCAN_DIV - 1);

  localparam logic [3:0] BLANK = 4'hF;

  state_t            state, state_next;
  logic [DATA_W-1:0] shift_reg, shift_reg_next;
  logic [11:0]       scratch, scratch_next, scratch_adj;
  logic [3:0]        bit_cnt, bit_cnt_next;
  logic              busy_next, done_next, load_digits;

  logic [PRE_W-1:0]  prescaler;
  logic [1:0]        scan_idx;
  logic [2:0]        en_sel;
  logic [3:0]        bcd_sel;
  logic              blank_h, blank_t;

  // Add-3 correction, applied to every nibble before each shift so that a
  // digit >= 5 carries correctly into the next nibble once doubled.
  always_comb begin
    scratch_adj = scratch;
    for (int i = 0; i < 3; i++) begin
      if (scratch[i*4 +: 4] >= 4'd5)
        scratch_adj[i*4 +: 4] = scratch[i*4 +: 4] + 4'd3;
    end
  end

  // Conversion state and datapath registers. Reset aborts any conversion in
  // flight and clears the published digits.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      shift_reg <= '0;
      scratch   <= '0;
      bit_cnt   <= '0;
      hundreds  <= 4'd0;
      tens      <= 4'd0;
      units     <= 4'd0;
    end else begin
      state     <= state_next;
      busy      <= busy_next;
      done      <= done_next;
      shift_reg <= shift_reg_next;
      scratch   <= scratch_next;
      bit_cnt   <= bit_cnt_next;
      if (load_digits) begin
        hundreds <= scratch[11:8];
        tens     <= scratch[7:4];
        units    <= scratch[3:0];
      end
    end
  end

  // Next-state and datapath control. Samples arriving while a conversion is
  // running are simply dropped; there is no queueing.
  always_comb begin
    state_next     = state;
    shift_reg_next = shift_reg;
    scratch_next   = scratch;
    bit_cnt_next   = bit_cnt;
    done_next      = 1'b0;
    load_digits    = 1'b0;

    case (state)
      IDLE: begin
        if (sample_valid) begin
          shift_reg_next = sample;
          scratch_next   = '0;
          bit_cnt_next   = BIT_COUNT;
          state_next     = SHIFT;
        end
      end
      SHIFT: begin
        // {scratch, shift_reg} shifts left as one long register: the sample
        // MSB moves into the scratch LSB.
        scratch_next   = {scratch_adj[10:0], shift_reg[DATA_W-1]};
        shift_reg_next = shift_reg << 1;
        bit_cnt_next   = bit_cnt - 4'd1;
        if (bit_cnt == 4'd1)
          state_next = DONE;
      end
      DONE: begin
        load_digits = 1'b1;
        done_next   = 1'b1;
        state_next  = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // busy is registered alongside the state so it is glitch-free.
  always_comb begin
    busy_next = (state_next != IDLE);
  end

  // Leading-zero blanking: the tens digit is only a leading zero when the
  // hundreds digit is zero as well. Units are always shown.
  always_comb begin
    blank_h = blank_lz && (hundreds == 4'd0);
    blank_t = blank_lz && (hundreds == 4'd0) && (tens == 4'd0);
  end

  // Digit selection for the scanner. It reads the registered digits, so a
  // conversion finishing mid-scan only shows on the next display update.
  always_comb begin
    en_sel  = 3'b001;
    bcd_sel = units;
    case (scan_idx)
      2'd0: begin
        en_sel  = 3'b001;
        bcd_sel = units;
      end
      2'd1: begin
        en_sel  = 3'b010;
        bcd_sel = blank_t ? BLANK : tens;
      end
      2'd2: begin
        en_sel  = 3'b100;
        bcd_sel = blank_h ? BLANK : hundreds;
      end
      default: begin
        en_sel  = 3'b001;
        bcd_sel = units;
      end
    endcase
  end

  // Free-running display scanner. The prescaler wraps every SCAN_DIV cycles
  // and steps the digit index; digit_en and bcd trail the index by one cycle.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      prescaler <= '0;
      scan_idx  <= 2'd0;
      digit_en  <= 3'b001;
      bcd       <= 4'h0;
    end else begin
      if (prescaler == PRE_MAX) begin
        prescaler <= '0;
        scan_idx  <= (scan_idx == 2'd2) ? 2'd0 : scan_idx + 2'd1;
      end else begin
        prescaler <= prescaler + 1'b1;
      end
      digit_en <= en_sel;
      bcd      <= bcd_sel;
    end
  end

endmodule

// File: tb/tb_adc_bcd_display.sv
// ---------------------------------------------------------------------------
// tb_adc_bcd_display
//
// Purpose:
//   Self-checking bench for adc_bcd_display (DATA_W=7, SCAN_DIV=4). Expected
//   digit triples are pushed to a queue when a sample is driven and popped
//   by a monitor whenever the DUT pulses done. Inputs change and outputs are
//   sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_adc_bcd_display;

  localparam int DATA_W   = 7;
  localparam int SCAN_DIV = 4;

  logic              CLK;
  logic              Reset;
  logic [DATA_W-1:0] sample;
  logic              sample_valid;
  logic              blank_lz;
  logic              busy;
  logic              done;
  logic [3:0]        hundreds, tens, units, bcd;
  logic [2:0]        digit_en;

  int errors = 0;
  int checks = 0;

  logic [11:0] exp_q[$];

  adc_bcd_display #(
    .DATA_W  (DATA_W),
    .SCAN_DIV(SCAN_DIV)
  ) dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .sample      (sample),
    .sample_valid(sample_valid),
    .blank_lz    (blank_lz),
    .busy        (busy),
    .done        (done),
    .hundreds    (hundreds),
    .tens        (tens),
    .units       (units),
    .bcd         (bcd),
    .digit_en    (digit_en)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // One comparison: counts it and reports observed/expected on a mismatch.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference conversion: packed {hundreds, tens, units}.
  function automatic logic [11:0] ref_bcd(input int v);
    logic [3:0] h, t, u;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    u = 4'(v % 10);
    return {h, t, u};
  endfunction

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  always @(negedge CLK) begin
    if (done === 1'b1) begin
      check("done_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0)
        check("digits", {20'd0, hundreds, tens, units}, {20'd0, exp_q.pop_front()});
    end
  end

  // Waits for the done pulse with a cycle budget.
  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (done !== 1'b1 && k < 20) begin
      @(negedge CLK);
      k++;
    end
    check(tag, 32'(done === 1'b1), 32'd1);
  endtask

  // Drives one single-cycle sample, records its expectation, waits for done.
  task automatic applyStimulus(input int v);
    sample       = DATA_W'(v);
    sample_valid = 1'b1;
    exp_q.push_back(ref_bcd(v));
    @(negedge CLK);
    sample_valid = 1'b0;
    wait_done($sformatf("timeout_%0d", v));
  endtask

  // Checks the scanned bus for a number of cycles: every bcd/digit_en pair
  // against the digits, each digit held SCAN_DIV cycles, rotation order.
  task automatic checkOutput(input logic [11:0] digs, input logic blank, input int cycles);
    logic [3:0] h, t, u, e;
    logic [2:0] prev_en, nxt;
    int run;
    bit first;
    h = digs[11:8];
    t = digs[7:4];
    u = digs[3:0];
    prev_en = digit_en;
    run = 0;
    first = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      case (digit_en)
        3'b001: e = u;
        3'b010: e = (blank && h == 4'd0 && t == 4'd0) ? 4'hF : t;
        3'b100: e = (blank && h == 4'd0) ? 4'hF : h;
        default: e = 4'hX;
      endcase
      check($sformatf("scan_bcd_en%03b", digit_en), {28'd0, bcd}, {28'd0, e});
      if (digit_en !== prev_en) begin
        nxt = (prev_en == 3'b100) ? 3'b001 : {prev_en[1:0], 1'b0};
        check("scan_order", {29'd0, digit_en}, {29'd0, nxt});
        if (!first)
          check("scan_hold", run, SCAN_DIV);
        first = 1'b0;
        run = 1;
        prev_en = digit_en;
      end else begin
        run++;
      end
      @(negedge CLK);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    int d1, d2, d3, c, n;

    // Reset state
    Reset = 1'b1;
    sample = '0;
    sample_valid = 1'b0;
    blank_lz = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_digits", {20'd0, hundreds, tens, units}, 32'd0);
    check("rst_digit_en", {29'd0, digit_en}, 32'b001);
    check("rst_bcd", {28'd0, bcd}, 32'd0);
    Reset = 1'b0;
    @(negedge CLK);

    // Test 1: 127, busy for 8 cycles, done after the 8th edge
    $display("[TB] test 1: sample 127 latency");
    sample = 7'd127;
    sample_valid = 1'b1;
    exp_q.push_back(ref_bcd(127));
    @(negedge CLK);
    sample_valid = 1'b0;
    check("t1_busy_0", 32'(busy), 32'd1);
    check("t1_done_0", 32'(done), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge CLK);
      check($sformatf("t1_busy_%0d", k), 32'(busy), 32'(k < 8));
      check($sformatf("t1_done_%0d", k), 32'(done), 32'(k == 8));
    end
    @(negedge CLK);
    check("t1_done_clear", 32'(done), 32'd0);

    // Test 2: zero with blanking, only the units digit visible
    $display("[TB] test 2: sample 0 blanked");
    blank_lz = 1'b1;
    applyStimulus(0);
    repeat (2) @(negedge CLK);
    checkOutput(ref_bcd(0), 1'b1, 3 * SCAN_DIV * 2 + 2);

    // Test 3: second sample while busy is dropped
    $display("[TB] test 3: sample while busy ignored");
    blank_lz = 1'b0;
    sample = 7'd99;
    sample_valid = 1'b1;
    exp_q.push_back(ref_bcd(99));
    @(negedge CLK);
    sample_valid = 1'b0;
    repeat (2) @(negedge CLK);
    sample = 7'd5;
    sample_valid = 1'b1;
    @(negedge CLK);
    sample_valid = 1'b0;
    wait_done("t3_timeout_99");
    @(negedge CLK);
    applyStimulus(5);
    repeat (12) @(negedge CLK);
    check("t3_no_extra", exp_q.size(), 0);

    // Test 4: 105 with blanking, scan order and tens zero not blanked
    $display("[TB] test 4: sample 105 scan");
    blank_lz = 1'b1;
    applyStimulus(105);
    repeat (2) @(negedge CLK);
    checkOutput(ref_bcd(105), 1'b1, 3 * SCAN_DIV * 2 + 3);

    // Test 5: reset in the middle of a conversion
    $display("[TB] test 5: reset aborts conversion");
    sample = 7'd64;
    sample_valid = 1'b1;
    @(negedge CLK);
    sample_valid = 1'b0;
    repeat (4) @(negedge CLK);
    check("t5_busy_before", 32'(busy), 32'd1);
    Reset = 1'b1;
    @(negedge CLK);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_digits", {20'd0, hundreds, tens, units}, 32'd0);
    check("t5_digit_en", {29'd0, digit_en}, 32'b001);
    Reset = 1'b0;
    repeat (15) @(negedge CLK);
    check("t5_busy_after", 32'(busy), 32'd0);
    check("t5_digits_after", {20'd0, hundreds, tens, units}, 32'd0);

    // Test 6: valid held high, one conversion every 9 cycles
    $display("[TB] test 6: back-to-back 42");
    blank_lz = 1'b0;
    sample = 7'd42;
    sample_valid = 1'b1;
    repeat (3) exp_q.push_back(ref_bcd(42));
    c = 0; n = 0; d1 = 0; d2 = 0; d3 = 0;
    while (n < 3 && c < 60) begin
      @(negedge CLK);
      c++;
      if (done === 1'b1) begin
        n++;
        if (n == 1) d1 = c;
        if (n == 2) d2 = c;
        if (n == 3) d3 = c;
      end
    end
    sample_valid = 1'b0;
    check("t6_count", n, 3);
    check("t6_first", d1, 9);
    check("t6_gap1", d2 - d1, 9);
    check("t6_gap2", d3 - d2, 9);
    @(negedge CLK);
    check("t6_idle", 32'(busy), 32'd0);

    // Sweep of the full input range
    $display("[TB] sweep 0..127");
    for (int v = 0; v < 128; v++) begin
      applyStimulus(v);
      @(negedge CLK);
    end

    repeat (12) @(negedge CLK);
    check("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
